// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle accumulator-CPU control path:
// opcode map, ALU operation codes, address-select codes, state/fault enums.
package cpu_pkg;

  // Opcode map (6-bit opcode field)
  localparam logic [5:0] OP_NOP    = 6'h00;
  localparam logic [5:0] OP_MOVI   = 6'h01;
  localparam logic [5:0] OP_MOVR   = 6'h02;
  localparam logic [5:0] OP_LOAD   = 6'h03;
  localparam logic [5:0] OP_STORE  = 6'h04;
  localparam logic [5:0] OP_LOADB  = 6'h05;
  localparam logic [5:0] OP_STOREB = 6'h06;
  localparam logic [5:0] OP_PUSH   = 6'h07;
  localparam logic [5:0] OP_POP    = 6'h08;
  localparam logic [5:0] OP_JMP    = 6'h09;
  localparam logic [5:0] OP_RET    = 6'h0A;
  localparam logic [5:0] OP_RAD    = 6'h0B;
  localparam logic [5:0] OP_POW    = 6'h0C;
  localparam logic [5:0] OP_BRA    = 6'h10;
  localparam logic [5:0] OP_BRE    = 6'h11;
  localparam logic [5:0] OP_BNE    = 6'h12;
  localparam logic [5:0] OP_BLT    = 6'h13;
  localparam logic [5:0] OP_BGE    = 6'h14;
  localparam logic [5:0] OP_BGT    = 6'h15;
  localparam logic [5:0] OP_BLE    = 6'h16;
  localparam logic [5:0] OP_BRC    = 6'h17;
  localparam logic [5:0] OP_BRO    = 6'h18;

  // ALU operation select codes
  localparam logic [4:0] ALU_PASSA = 5'd0;
  localparam logic [4:0] ALU_PASSB = 5'd1;
  localparam logic [4:0] ALU_ADD   = 5'd2;
  localparam logic [4:0] ALU_SUB   = 5'd3;
  localparam logic [4:0] ALU_RAD   = 5'd4;
  localparam logic [4:0] ALU_POW   = 5'd5;

  // data_addr_sel codes
  localparam logic [1:0] DA_ALU     = 2'd0;
  localparam logic [1:0] DA_IMM     = 2'd1;
  localparam logic [1:0] DA_SP      = 2'd2;
  localparam logic [1:0] DA_SP_NEXT = 2'd3;

  // Architectural register indices
  localparam int REG_X   = 0;
  localparam int REG_Y   = 1;
  localparam int REG_ACC = 2;

  typedef enum logic [2:0] {
    ST_FETCH    = 3'd0,
    ST_DECODE   = 3'd1,
    ST_EXEC     = 3'd2,
    ST_ALU_WAIT = 3'd3,
    ST_MEM      = 3'd4,
    ST_FAULT    = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    FLT_NONE      = 2'd0,
    FLT_ILLEGAL   = 2'd1,
    FLT_OVERFLOW  = 2'd2,
    FLT_UNDERFLOW = 2'd3
  } fault_e;

  typedef enum logic [1:0] {
    CLS_SINGLE = 2'd0,
    CLS_ALU    = 2'd1,
    CLS_MEM    = 2'd2
  } iclass_e;

  typedef enum logic [3:0] {
    CND_NONE, CND_AL, CND_EQ, CND_NE, CND_LT,
    CND_GE, CND_GT, CND_LE, CND_CS, CND_VS
  } cond_e;

  // Evaluate a branch condition against latched flags {Z,N,C,O}
  function automatic logic cond_true(input cond_e c, input logic [3:0] f);
    logic z, n, cy, o, res;
    z  = f[3];
    n  = f[2];
    cy = f[1];
    o  = f[0];
    case (c)
      CND_AL:  res = 1'b1;
      CND_EQ:  res = z;
      CND_NE:  res = !z;
      CND_LT:  res = (n != o);
      CND_GE:  res = (n == o);
      CND_GT:  res = !z && (n == o);
      CND_LE:  res = z || (n != o);
      CND_CS:  res = cy;
      CND_VS:  res = o;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction classifier: ir -> class, ALU controls, memory
// controls, register write mask, stack markers and illegal-opcode flag.
module instr_decoder
  import cpu_pkg::*;
#(
  parameter int INSTR_W  = 16,
  parameter int OPC_W    = 6,
  parameter int NUM_REGS = 3,
  localparam int REG_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
  localparam int SRC_W   = $clog2(NUM_REGS + 1)
) (
  input  logic [INSTR_W-1:0]  ir,
  output iclass_e             iclass,
  output logic [4:0]          opsel,
  output logic [SRC_W-1:0]    sel_a,
  output logic [SRC_W-1:0]    sel_b,
  output logic [1:0]          addr_sel,
  output logic                mem_we,
  output logic [SRC_W-1:0]    data_sel,
  output logic                reg_from_mem,
  output logic [NUM_REGS-1:0] wr_mask,
  output logic                is_push,
  output logic                is_pop,
  output logic                is_stack,
  output logic                is_jmp,
  output logic                is_ret,
  output cond_e               cond,
  output logic                illegal
);

  localparam int LOW_W = INSTR_W - OPC_W - REG_W - SRC_W;
  localparam logic [SRC_W-1:0] SRC_IMM = SRC_W'(NUM_REGS);
  localparam logic [SRC_W-1:0] SRC_ACC = SRC_W'(REG_ACC);

  logic [OPC_W-1:0]    opc;
  logic [REG_W-1:0]    rd;
  logic [SRC_W-1:0]    rs;
  logic [NUM_REGS-1:0] rd_oh;
  logic [NUM_REGS-1:0] acc_oh;
  logic                unused_imm;

  assign opc        = ir[INSTR_W-1 -: OPC_W];
  assign rd         = ir[INSTR_W-OPC_W-1 -: REG_W];
  assign rs         = ir[INSTR_W-OPC_W-REG_W-1 -: SRC_W];
  assign rd_oh      = NUM_REGS'(1) << rd;
  assign acc_oh     = NUM_REGS'(1) << REG_ACC;
  assign unused_imm = ^ir[LOW_W-1:0];

  // Opcode classification and control decode
  always_comb begin
    iclass       = CLS_SINGLE;
    opsel        = ALU_PASSA;
    sel_a        = '0;
    sel_b        = '0;
    addr_sel     = DA_ALU;
    mem_we       = 1'b0;
    data_sel     = '0;
    reg_from_mem = 1'b0;
    wr_mask      = '0;
    is_push      = 1'b0;
    is_pop       = 1'b0;
    is_stack     = 1'b0;
    is_jmp       = 1'b0;
    is_ret       = 1'b0;
    cond         = CND_NONE;
    illegal      = 1'b0;
    case (opc)
      OPC_W'(OP_NOP): ;
      OPC_W'(OP_MOVI): begin
        sel_a   = SRC_IMM;
        wr_mask = rd_oh;
      end
      OPC_W'(OP_MOVR): begin
        sel_a   = rs;
        wr_mask = rd_oh;
      end
      OPC_W'(OP_LOAD): begin
        iclass       = CLS_MEM;
        addr_sel     = DA_IMM;
        reg_from_mem = 1'b1;
        wr_mask      = rd_oh;
      end
      OPC_W'(OP_STORE): begin
        iclass   = CLS_MEM;
        addr_sel = DA_IMM;
        mem_we   = 1'b1;
        data_sel = SRC_W'(rd);
      end
      OPC_W'(OP_LOADB): begin
        iclass       = CLS_MEM;
        opsel        = ALU_ADD;
        sel_a        = rs;
        sel_b        = SRC_IMM;
        reg_from_mem = 1'b1;
        wr_mask      = rd_oh;
      end
      OPC_W'(OP_STOREB): begin
        iclass   = CLS_MEM;
        opsel    = ALU_ADD;
        sel_a    = rs;
        sel_b    = SRC_IMM;
        mem_we   = 1'b1;
        data_sel = SRC_W'(rd);
      end
      OPC_W'(OP_PUSH): begin
        iclass   = CLS_MEM;
        addr_sel = DA_SP;
        mem_we   = 1'b1;
        data_sel = SRC_W'(rd);
        is_push  = 1'b1;
        is_stack = 1'b1;
      end
      OPC_W'(OP_POP): begin
        iclass       = CLS_MEM;
        addr_sel     = DA_SP_NEXT;
        reg_from_mem = 1'b1;
        wr_mask      = rd_oh;
        is_pop       = 1'b1;
        is_stack     = 1'b1;
      end
      OPC_W'(OP_JMP): begin
        iclass   = CLS_MEM;
        opsel    = ALU_PASSB;
        sel_b    = SRC_IMM;
        addr_sel = DA_SP;
        mem_we   = 1'b1;
        data_sel = SRC_IMM;
        is_push  = 1'b1;
        is_stack = 1'b1;
        is_jmp   = 1'b1;
      end
      OPC_W'(OP_RET): begin
        iclass   = CLS_MEM;
        addr_sel = DA_SP_NEXT;
        is_pop   = 1'b1;
        is_stack = 1'b1;
        is_ret   = 1'b1;
      end
      OPC_W'(OP_RAD), OPC_W'(OP_POW): begin
        iclass  = CLS_ALU;
        opsel   = (opc == OPC_W'(OP_RAD)) ? ALU_RAD : ALU_POW;
        sel_a   = SRC_ACC;
        sel_b   = rs;
        wr_mask = acc_oh;
      end
      OPC_W'(OP_BRA), OPC_W'(OP_BRE), OPC_W'(OP_BNE), OPC_W'(OP_BLT),
      OPC_W'(OP_BGE), OPC_W'(OP_BGT), OPC_W'(OP_BLE), OPC_W'(OP_BRC),
      OPC_W'(OP_BRO): begin
        opsel = ALU_ADD;
        sel_a = SRC_IMM;
        sel_b = SRC_IMM;
        case (opc)
          OPC_W'(OP_BRA): cond = CND_AL;
          OPC_W'(OP_BRE): cond = CND_EQ;
          OPC_W'(OP_BNE): cond = CND_NE;
          OPC_W'(OP_BLT): cond = CND_LT;
          OPC_W'(OP_BGE): cond = CND_GE;
          OPC_W'(OP_BGT): cond = CND_GT;
          OPC_W'(OP_BLE): cond = CND_LE;
          OPC_W'(OP_BRC): cond = CND_CS;
          default:        cond = CND_VS;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/seq_control_unit.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC sequencing with ALU and
// data-memory wait states, stack-depth tracking and sticky fault reporting.
module seq_control_unit
  import cpu_pkg::*;
#(
  parameter int INSTR_W     = 16,
  parameter int OPC_W       = 6,
  parameter int NUM_REGS    = 3,
  parameter int STACK_DEPTH = 16,
  localparam int SRC_W      = $clog2(NUM_REGS + 1),
  localparam int SP_W       = $clog2(STACK_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                instr_valid,
  input  logic [INSTR_W-1:0]  instr,
  output logic                instr_ready,
  input  logic [3:0]          flags,
  output logic [4:0]          opsel,
  output logic [SRC_W-1:0]    sel_srcA,
  output logic [SRC_W-1:0]    sel_srcB,
  output logic                alu_start,
  input  logic                alu_done,
  output logic                mem_req,
  output logic                mem_we,
  input  logic                mem_ack,
  output logic [1:0]          data_addr_sel,
  output logic [SRC_W-1:0]    mem_data_wr_sel,
  output logic                reg_from_mem,
  output logic [NUM_REGS-1:0] wr_en,
  output logic                save_flags,
  output logic                branch,
  output logic                ret,
  output logic                loadPC,
  output logic                push,
  output logic                op_stack,
  output logic                busy,
  output logic                fault,
  output logic [1:0]          fault_code
);

  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  state_e               state_q, state_d;
  logic [INSTR_W-1:0]   ir_q, ir_d;
  logic [SP_W-1:0]      sp_q, sp_d;
  logic [3:0]           flag_q, flag_d;
  fault_e               fault_q, fault_d;

  iclass_e              dec_class;
  logic [4:0]           dec_opsel;
  logic [SRC_W-1:0]     dec_sel_a, dec_sel_b, dec_data_sel;
  logic [1:0]           dec_addr_sel;
  logic                 dec_mem_we, dec_rfm;
  logic [NUM_REGS-1:0]  dec_wr_mask;
  logic                 dec_push, dec_pop, dec_stack, dec_jmp, dec_ret;
  cond_e                dec_cond;
  logic                 dec_illegal;

  instr_decoder #(
    .INSTR_W  (INSTR_W),
    .OPC_W    (OPC_W),
    .NUM_REGS (NUM_REGS)
  ) u_dec (
    .ir           (ir_q),
    .iclass       (dec_class),
    .opsel        (dec_opsel),
    .sel_a        (dec_sel_a),
    .sel_b        (dec_sel_b),
    .addr_sel     (dec_addr_sel),
    .mem_we       (dec_mem_we),
    .data_sel     (dec_data_sel),
    .reg_from_mem (dec_rfm),
    .wr_mask      (dec_wr_mask),
    .is_push      (dec_push),
    .is_pop       (dec_pop),
    .is_stack     (dec_stack),
    .is_jmp       (dec_jmp),
    .is_ret       (dec_ret),
    .cond         (dec_cond),
    .illegal      (dec_illegal)
  );

  // Next-state, instruction latch, stack depth and fault capture
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    sp_d    = sp_q;
    flag_d  = flag_q;
    fault_d = fault_q;
    case (state_q)
      ST_FETCH: begin
        if (instr_valid) begin
          ir_d    = instr;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (dec_illegal) begin
          fault_d = FLT_ILLEGAL;
          state_d = ST_FAULT;
        end else if (dec_push && (sp_q == SP_FULL)) begin
          fault_d = FLT_OVERFLOW;
          state_d = ST_FAULT;
        end else if (dec_pop && (sp_q == '0)) begin
          fault_d = FLT_UNDERFLOW;
          state_d = ST_FAULT;
        end else begin
          flag_d  = flags;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (dec_class)
          CLS_ALU: state_d = ST_ALU_WAIT;
          CLS_MEM: state_d = ST_MEM;
          default: state_d = ST_FETCH;
        endcase
      end
      ST_ALU_WAIT: begin
        if (alu_done) state_d = ST_FETCH;
      end
      ST_MEM: begin
        if (mem_ack) begin
          state_d = ST_FETCH;
          if (dec_push) sp_d = sp_q + SP_W'(1);
          if (dec_pop)  sp_d = sp_q - SP_W'(1);
        end
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_FETCH;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_FETCH;
      ir_q    <= '0;
      sp_q    <= '0;
      flag_q  <= '0;
      fault_q <= FLT_NONE;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      sp_q    <= sp_d;
      flag_q  <= flag_d;
      fault_q <= fault_d;
    end
  end

  // Output decode; only the final-cycle strobes look at alu_done/mem_ack
  always_comb begin
    instr_ready     = (state_q == ST_FETCH);
    busy            = (state_q != ST_FETCH);
    fault           = (state_q == ST_FAULT);
    fault_code      = fault_q;
    opsel           = '0;
    sel_srcA        = '0;
    sel_srcB        = '0;
    alu_start       = 1'b0;
    mem_req         = 1'b0;
    mem_we          = 1'b0;
    data_addr_sel   = '0;
    mem_data_wr_sel = '0;
    reg_from_mem    = 1'b0;
    wr_en           = '0;
    save_flags      = 1'b0;
    branch          = 1'b0;
    ret             = 1'b0;
    loadPC          = 1'b0;
    push            = 1'b0;
    op_stack        = 1'b0;
    if (state_q == ST_EXEC || state_q == ST_ALU_WAIT || state_q == ST_MEM) begin
      opsel    = dec_opsel;
      sel_srcA = dec_sel_a;
      sel_srcB = dec_sel_b;
    end
    case (state_q)
      ST_EXEC: begin
        if (dec_class == CLS_SINGLE) begin
          wr_en  = dec_wr_mask;
          branch = cond_true(dec_cond, flag_q);
          loadPC = 1'b1;
        end else if (dec_class == CLS_ALU) begin
          alu_start = 1'b1;
        end
      end
      ST_ALU_WAIT: begin
        if (alu_done) begin
          wr_en      = dec_wr_mask;
          save_flags = 1'b1;
          loadPC     = 1'b1;
        end
      end
      ST_MEM: begin
        mem_req         = 1'b1;
        mem_we          = dec_mem_we;
        data_addr_sel   = dec_addr_sel;
        mem_data_wr_sel = dec_data_sel;
        if (mem_ack) begin
          wr_en        = dec_wr_mask;
          reg_from_mem = dec_rfm;
          push         = dec_push;
          op_stack     = dec_stack;
          branch       = dec_jmp;
          ret          = dec_ret;
          loadPC       = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_seq_control_unit.sv
// Directed bench for seq_control_unit (STACK_DEPTH=2 instance).
module tb_seq_control_unit;
  import cpu_pkg::*;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [3:0]  flags;
  logic [4:0]  opsel;
  logic [1:0]  sel_srcA, sel_srcB;
  logic        alu_start, alu_done;
  logic        mem_req, mem_we, mem_ack;
  logic [1:0]  data_addr_sel;
  logic [1:0]  mem_data_wr_sel;
  logic        reg_from_mem;
  logic [2:0]  wr_en;
  logic        save_flags, branch, ret, loadPC, push, op_stack;
  logic        busy, fault;
  logic [1:0]  fault_code;

  int total = 0;
  int bad   = 0;

  seq_control_unit #(
    .INSTR_W     (16),
    .OPC_W       (6),
    .NUM_REGS    (3),
    .STACK_DEPTH (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .instr_valid     (instr_valid),
    .instr           (instr),
    .instr_ready     (instr_ready),
    .flags           (flags),
    .opsel           (opsel),
    .sel_srcA        (sel_srcA),
    .sel_srcB        (sel_srcB),
    .alu_start       (alu_start),
    .alu_done        (alu_done),
    .mem_req         (mem_req),
    .mem_we          (mem_we),
    .mem_ack         (mem_ack),
    .data_addr_sel   (data_addr_sel),
    .mem_data_wr_sel (mem_data_wr_sel),
    .reg_from_mem    (reg_from_mem),
    .wr_en           (wr_en),
    .save_flags      (save_flags),
    .branch          (branch),
    .ret             (ret),
    .loadPC          (loadPC),
    .push            (push),
    .op_stack        (op_stack),
    .busy            (busy),
    .fault           (fault),
    .fault_code      (fault_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [15:0] enc(input logic [5:0] op, input logic [1:0] rd,
                                      input logic [1:0] rs);
    return {op, rd, rs, 6'h00};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // FETCH -> DECODE -> EXEC for a single-cycle instruction; flags are
  // inverted once DECODE has passed to show they were latched there.
  task automatic run_single(input logic [15:0] ins, input logic [3:0] fl,
                            input logic exp_br, input logic [2:0] exp_wr,
                            input logic [1:0] exp_sa, input string tag);
    instr_valid = 1'b1;
    instr       = ins;
    flags       = fl;
    #1;
    chk({tag, ".ready"}, 32'(instr_ready), 32'd1);
    tick();
    instr_valid = 1'b0;
    #1;
    chk({tag, ".dec_busy"}, 32'({busy, instr_ready, loadPC}), 32'b100);
    tick();
    flags = ~fl;
    #1;
    chk({tag, ".branch"}, 32'(branch), 32'(exp_br));
    chk({tag, ".loadPC"}, 32'(loadPC), 32'd1);
    chk({tag, ".wr_en"}, 32'(wr_en), 32'(exp_wr));
    chk({tag, ".srcA"}, 32'(sel_srcA), 32'(exp_sa));
    tick();
  endtask

  // Memory-class instruction with ack in its first MEM cycle.
  // exp_strb = {push, op_stack, branch, ret}
  task automatic run_mem(input logic [15:0] ins, input logic exp_we,
                         input logic [1:0] exp_as, input logic [1:0] exp_ds,
                         input logic [2:0] exp_wr, input logic [3:0] exp_strb,
                         input string tag);
    instr_valid = 1'b1;
    instr       = ins;
    tick();
    instr_valid = 1'b0;
    tick();
    #1;
    chk({tag, ".exec_noreq"}, 32'({mem_req, loadPC}), 32'b00);
    tick();
    mem_ack = 1'b1;
    #1;
    chk({tag, ".req_we"}, 32'({mem_req, mem_we}), 32'({1'b1, exp_we}));
    chk({tag, ".addr_sel"}, 32'(data_addr_sel), 32'(exp_as));
    chk({tag, ".data_sel"}, 32'(mem_data_wr_sel), 32'(exp_ds));
    chk({tag, ".wr_en"}, 32'(wr_en), 32'(exp_wr));
    chk({tag, ".strobes"}, 32'({push, op_stack, branch, ret}), 32'(exp_strb));
    chk({tag, ".loadPC"}, 32'(loadPC), 32'd1);
    tick();
    mem_ack = 1'b0;
  endtask

  // Instruction expected to fault in DECODE; a POP stays offered afterwards.
  task automatic run_fault(input logic [15:0] ins, input logic [1:0] exp_code,
                           input string tag);
    instr_valid = 1'b1;
    instr       = ins;
    tick();
    instr = enc(OP_POP, 2'd0, 2'd0);
    tick();
    #1;
    chk({tag, ".fault"}, 32'({fault, fault_code}), 32'({1'b1, exp_code}));
    chk({tag, ".quiet"}, 32'({mem_req, instr_ready, loadPC, wr_en}), 32'd0);
    tick();
    tick();
    #1;
    chk({tag, ".held"}, 32'({fault, fault_code, instr_ready}), 32'({1'b1, exp_code, 1'b0}));
    instr_valid = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk({tag, ".reset"}, 32'({fault, fault_code, instr_ready, busy}), 32'b00010);
  endtask

  initial begin
    rst         = 1'b0;
    instr_valid = 1'b0;
    instr       = '0;
    flags       = '0;
    alu_done    = 1'b0;
    mem_ack     = 1'b0;
    tick();
    tick();
    #1;
    chk("rst.ready_busy", 32'({instr_ready, busy, fault, fault_code}), 32'b10000);
    chk("rst.strobes", 32'({mem_req, alu_start, loadPC, wr_en, save_flags, branch}), 32'd0);
    rst = 1'b1;

    // Single-cycle class
    run_single(enc(OP_MOVI, 2'd0, 2'd0), 4'b0000, 1'b0, 3'b001, 2'd3, "movi_x");
    #1;
    chk("movi_x.next_accept", 32'(instr_ready), 32'd1);
    run_single(enc(OP_BNE, 2'd0, 2'd0), 4'b1000, 1'b0, 3'b000, 2'd3, "bne_z1");
    run_single(enc(OP_BNE, 2'd0, 2'd0), 4'b0000, 1'b1, 3'b000, 2'd3, "bne_z0");
    run_single(enc(OP_BLT, 2'd0, 2'd0), 4'b0100, 1'b1, 3'b000, 2'd3, "blt");
    run_single(enc(OP_BGT, 2'd0, 2'd0), 4'b0000, 1'b1, 3'b000, 2'd3, "bgt_t");
    run_single(enc(OP_BGT, 2'd0, 2'd0), 4'b1000, 1'b0, 3'b000, 2'd3, "bgt_f");
    run_single(enc(OP_BLE, 2'd0, 2'd0), 4'b0101, 1'b0, 3'b000, 2'd3, "ble_f");
    run_single(enc(OP_BRC, 2'd0, 2'd0), 4'b0010, 1'b1, 3'b000, 2'd3, "brc");
    run_single(enc(OP_BRO, 2'd0, 2'd0), 4'b0000, 1'b0, 3'b000, 2'd3, "bro");
    run_single(enc(OP_MOVR, 2'd1, 2'd2), 4'b0000, 1'b0, 3'b010, 2'd2, "movr_y_acc");
    run_single(enc(OP_NOP, 2'd0, 2'd0), 4'b0000, 1'b0, 3'b000, 2'd0, "nop");

    // LOAD Y, ack in third MEM cycle; stray ack/done in EXEC are ignored
    instr_valid = 1'b1;
    instr       = enc(OP_LOAD, 2'd1, 2'd0);
    tick();
    instr_valid = 1'b0;
    tick();
    mem_ack  = 1'b1;
    alu_done = 1'b1;
    #1;
    chk("load.exec_noreq", 32'(mem_req), 32'd0);
    tick();
    mem_ack  = 1'b0;
    alu_done = 1'b0;
    #1;
    chk("load.m1", 32'({mem_req, mem_we, data_addr_sel, reg_from_mem, wr_en, loadPC}),
        32'({1'b1, 1'b0, 2'd1, 1'b0, 3'b000, 1'b0}));
    tick();
    #1;
    chk("load.m2", 32'({mem_req, data_addr_sel, wr_en, loadPC}), 32'({1'b1, 2'd1, 3'b000, 1'b0}));
    tick();
    mem_ack = 1'b1;
    #1;
    chk("load.ack", 32'({mem_req, data_addr_sel, reg_from_mem, wr_en, loadPC}),
        32'({1'b1, 2'd1, 1'b1, 3'b010, 1'b1}));
    tick();
    mem_ack = 1'b0;
    #1;
    chk("load.after", 32'({mem_req, reg_from_mem, wr_en, instr_ready}), 32'({1'b0, 1'b0, 3'b000, 1'b1}));

    // POW with alu_done in the fifth ALU_WAIT cycle
    instr_valid = 1'b1;
    instr       = enc(OP_POW, 2'd2, 2'd1);
    tick();
    instr_valid = 1'b0;
    tick();
    #1;
    chk("pow.start", 32'({alu_start, opsel}), 32'({1'b1, ALU_POW}));
    for (int i = 1; i <= 4; i++) begin
      tick();
      #1;
      chk("pow.wait", 32'({alu_start, opsel, wr_en, save_flags, loadPC, busy}),
          32'({1'b0, ALU_POW, 3'b000, 1'b0, 1'b0, 1'b1}));
      if (i == 1) chk("pow.srcB", 32'(sel_srcB), 32'd1);
    end
    tick();
    alu_done = 1'b1;
    #1;
    chk("pow.done", 32'({alu_start, opsel, wr_en, save_flags, loadPC}),
        32'({1'b0, ALU_POW, 3'b100, 1'b1, 1'b1}));
    tick();
    alu_done = 1'b0;
    #1;
    chk("pow.after", 32'({instr_ready, save_flags, wr_en}), 32'({1'b1, 1'b0, 3'b000}));

    // Reset in the middle of a memory wait drops the request
    instr_valid = 1'b1;
    instr       = enc(OP_LOAD, 2'd0, 2'd0);
    tick();
    instr_valid = 1'b0;
    tick();
    tick();
    #1;
    chk("rstmem.req", 32'(mem_req), 32'd1);
    rst = 1'b0;
    tick();
    #1;
    chk("rstmem.dropped", 32'({mem_req, instr_ready}), 32'b01);
    rst = 1'b1;

    // STORE from ACC
    run_mem(enc(OP_STORE, 2'd2, 2'd0), 1'b1, 2'd1, 2'd2, 3'b000, 4'b0000, "store_acc");

    // Stack overflow at depth 2
    run_mem(enc(OP_PUSH, 2'd0, 2'd0), 1'b1, 2'd2, 2'd0, 3'b000, 4'b1100, "push1");
    run_mem(enc(OP_PUSH, 2'd1, 2'd0), 1'b1, 2'd2, 2'd1, 3'b000, 4'b1100, "push2");
    run_fault(enc(OP_JMP, 2'd0, 2'd0), 2'd2, "jmp_ovf");
    do_reset("ovf");

    // Underflow straight after reset
    run_fault(enc(OP_RET, 2'd0, 2'd0), 2'd3, "ret_unf");
    do_reset("unf");

    // PUSH then RET balances; a second RET underflows
    run_mem(enc(OP_PUSH, 2'd0, 2'd0), 1'b1, 2'd2, 2'd0, 3'b000, 4'b1100, "push3");
    run_mem(enc(OP_RET, 2'd0, 2'd0), 1'b0, 2'd3, 2'd0, 3'b000, 4'b0101, "ret_ok");
    run_fault(enc(OP_RET, 2'd0, 2'd0), 2'd3, "ret_unf2");
    do_reset("unf2");

    // PUSH/POP Y, then a call with room on the stack
    run_mem(enc(OP_PUSH, 2'd1, 2'd0), 1'b1, 2'd2, 2'd1, 3'b000, 4'b1100, "push4");
    run_mem(enc(OP_POP, 2'd1, 2'd0), 1'b0, 2'd3, 2'd0, 3'b010, 4'b0100, "pop_y");
    run_mem(enc(OP_JMP, 2'd0, 2'd0), 1'b1, 2'd2, 2'd3, 3'b000, 4'b1110, "jmp_ok");

    // Undefined opcode
    run_fault(enc(6'h3F, 2'd0, 2'd0), 2'd1, "illegal");
    do_reset("ill");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
